// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds FSM states, priority-select codes and the control bundle.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    SEL_OFF,
    SEL_MEM,
    SEL_BR,
    SEL_LU,
    SEL_RUN
  } sel_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wr;
    logic if_id_f;
    logic id_ex_f;
    logic mem_wr_f;
  } ctl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signals seen by the stall/flush sequencer.
// master = sequencer, slave = pipeline datapath / memory.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_uses_rt;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Rw;
  logic             EX_branch_taken;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_en;
  logic             IF_ID_en;
  logic             ID_EX_en;
  logic             EX_MEM_en;
  logic             MEM_WR_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             MEM_WR_flush;

  modport master (
    input  ID_Rs, ID_Rt, ID_uses_rt,
    input  EX_MemRead, EX_Rw,
    input  EX_branch_taken,
    input  MEM_MemRead, MEM_MemWrite,
    input  dmem_ready,
    output dmem_req,
    output pc_en, IF_ID_en, ID_EX_en,
    output EX_MEM_en, MEM_WR_en,
    output IF_ID_flush, ID_EX_flush,
    output MEM_WR_flush
  );

  modport slave (
    output ID_Rs, ID_Rt, ID_uses_rt,
    output EX_MemRead, EX_Rw,
    output EX_branch_taken,
    output MEM_MemRead, MEM_MemWrite,
    output dmem_ready,
    input  dmem_req,
    input  pc_en, IF_ID_en, ID_EX_en,
    input  EX_MEM_en, MEM_WR_en,
    input  IF_ID_flush, ID_EX_flush,
    input  MEM_WR_flush
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the reader in ID.
// r0 is never a real dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rw,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = EX_Rw == ID_Rs;
  assign rt_hit = ID_uses_rt & (EX_Rw == ID_Rt);
  assign lu = EX_MemRead & (EX_Rw != '0)
            & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards,
// branch squash, dmem wait with timeout, perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.master  bus,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(MEM_TIMEOUT - 1);

  state_e          state;
  logic [WC_W-1:0] wait_cnt;
  sel_e            sel;
  ctl_t            ctl;
  logic            lu;
  logic            mem_acc;
  logic            halted;
  logic            mem_stall;
  logic            br;
  logic            to_hit;
  logic            stall_inc;
  logic            flush_inc;

  hazard_detect u_hd (
    .ID_Rs      (bus.ID_Rs),
    .ID_Rt      (bus.ID_Rt),
    .ID_uses_rt (bus.ID_uses_rt),
    .EX_MemRead (bus.EX_MemRead),
    .EX_Rw      (bus.EX_Rw),
    .lu         (lu)
  );

  assign br        = bus.EX_branch_taken;
  assign mem_acc   = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign halted    = state == HALT;
  assign mem_stall = mem_acc & ~bus.dmem_ready & ~halted;
  assign to_hit    = wait_cnt == WC_LAST;
  assign err       = halted;
  assign stall_inc = mem_stall | (lu & ~br);
  assign flush_inc = br & ~mem_stall & ~halted;

  always_comb begin
    sel = SEL_RUN;
    if (rst || halted) sel = SEL_OFF;
    else if (mem_stall) sel = SEL_MEM;
    else if (br)        sel = SEL_BR;
    else if (lu)        sel = SEL_LU;
  end

  always_comb begin
    ctl = '0;
    unique case (sel)
      SEL_OFF: ctl = '0;
      SEL_MEM: ctl.mem_wr_f = 1'b1;
      SEL_BR:  ctl = 8'b11111_110;
      SEL_LU:  ctl = 8'b00111_010;
      SEL_RUN: ctl = 8'b11111_000;
      default: ctl = '0;
    endcase
  end

  assign bus.dmem_req     = mem_acc & (sel != SEL_OFF);
  assign bus.pc_en        = ctl.pc;
  assign bus.IF_ID_en     = ctl.if_id;
  assign bus.ID_EX_en     = ctl.id_ex;
  assign bus.EX_MEM_en    = ctl.ex_mem;
  assign bus.MEM_WR_en    = ctl.mem_wr;
  assign bus.IF_ID_flush  = ctl.if_id_f;
  assign bus.ID_EX_flush  = ctl.id_ex_f;
  assign bus.MEM_WR_flush = ctl.mem_wr_f;

  // wait_cnt indexes the current stalled cycle, so HALT
  // follows exactly MEM_TIMEOUT stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            if (to_hit) begin
              state <= HALT;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (to_hit) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
